// File: rtl/fault_io_pkg.sv
// Shared constants for the fault input conditioner: channel counts,
// idle levels and the debounce counter width.
package fault_io_pkg;

   localparam int   N_MOT     = 5;
   localparam int   N_SENS    = 3;
   localparam int   CNT_W     = 8;
   localparam logic MOT_IDLE  = 1'b0;
   localparam logic SENS_IDLE = 1'b1;

endpackage

// File: rtl/debounce_ch.sv
// One raw input channel: two-flop synchroniser, then a debounce counter.
// The counter filters the synchronised level before it reaches the registered output.
module debounce_ch
   import fault_io_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic IDLE_LVL        = 1'b0
) (
   input  logic CLK,
   input  logic RST,
   input  logic RAW,
   output logic OUT,
   output logic OUT_NXT
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // Any synchronised sample that agrees with the output restarts the run,
   // so only an unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
   always_comb begin
      OUT_NXT = OUT;
      cnt_nxt = cnt + CNT_W'(1);
      if (s2 == OUT) begin
         cnt_nxt = '0;
      end else if (cnt == CNT_LAST) begin
         OUT_NXT = s2;
         cnt_nxt = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1  <= IDLE_LVL;
         s2  <= IDLE_LVL;
         cnt <= '0;
         OUT <= IDLE_LVL;
      end else begin
         s1  <= RAW;
         s2  <= s1;
         cnt <= cnt_nxt;
         OUT <= OUT_NXT;
      end
   end

endmodule

// File: rtl/fault_input_conditioner.sv
// Synchronises and debounces the motor-error and fail-sensor lines.
// It also derives a registered any-fault flag and a one-cycle fault-entry pulse.
module fault_input_conditioner
   import fault_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [N_MOT-1:0]  MOT_ERR_RAW,
   input  logic [N_SENS-1:0] FAIL_SENSn_RAW,
   output logic [N_MOT-1:0]  MOT_ERR,
   output logic [N_SENS-1:0] FAIL_SENSn,
   output logic              FAULT_EVT,
   output logic              FAULT_ANY
);

   logic [N_MOT-1:0]        mot_nxt;
   logic [N_SENS-1:0]       sens_nxt;
   logic [N_MOT+N_SENS-1:0] fault_cur;
   logic [N_MOT+N_SENS-1:0] fault_nxt;

   for (genvar i = 0; i < N_MOT; i++) begin : g_mot
      debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_LVL        (MOT_IDLE)
      ) u_ch (
         .CLK     (CLK),
         .RST     (RST),
         .RAW     (MOT_ERR_RAW[i]),
         .OUT     (MOT_ERR[i]),
         .OUT_NXT (mot_nxt[i])
      );
   end

   for (genvar i = 0; i < N_SENS; i++) begin : g_sens
      debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_LVL        (SENS_IDLE)
      ) u_ch (
         .CLK     (CLK),
         .RST     (RST),
         .RAW     (FAIL_SENSn_RAW[i]),
         .OUT     (FAIL_SENSn[i]),
         .OUT_NXT (sens_nxt[i])
      );
   end

   // Fault flags are built from next-state levels so they land on the same edge as the outputs.
   assign fault_cur = {~FAIL_SENSn, MOT_ERR};
   assign fault_nxt = {~sens_nxt, mot_nxt};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         FAULT_EVT <= 1'b0;
         FAULT_ANY <= 1'b0;
      end else begin
         FAULT_EVT <= |(fault_nxt & ~fault_cur);
         FAULT_ANY <= |fault_nxt;
      end
   end

endmodule

// File: tb/tb_fault_input_conditioner.sv
// Randomised and directed bench for fault_input_conditioner.
// A window-based reference model feeds a scoreboard that a separate monitor drains.
module tb_fault_input_conditioner;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] mot_raw = 5'b00000;
   logic [2:0] sens_raw = 3'b111;
   logic [4:0] mot_err;
   logic [2:0] fail_sensn;
   logic       fault_evt;
   logic       fault_any;

   int checks = 0;
   int failures = 0;
   int evt_count = 0;

   typedef struct packed {
      logic [4:0] mot;
      logic [2:0] sens;
      logic       evt;
      logic       any;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] hist_q[$];
   logic [7:0] win_q[$];
   logic [7:0] mdl_out;

   fault_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .CLK            (clk),
      .RST            (rst),
      .MOT_ERR_RAW    (mot_raw),
      .FAIL_SENSn_RAW (sens_raw),
      .MOT_ERR        (mot_err),
      .FAIL_SENSn     (fail_sensn),
      .FAULT_EVT      (fault_evt),
      .FAULT_ANY      (fault_any)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic [4:0] mot, input logic [2:0] sens);
      @(negedge clk);
      mot_raw  = mot;
      sens_raw = sens;
   endtask

   // Reference model in the fault domain (1 = fault): each edge looks at the raw sample
   // taken two edges earlier; a channel flips once its last D such samples all differ from it.
   initial begin
      exp_t       e;
      logic [7:0] nxt;
      logic       flip;
      forever begin
         @(posedge clk);
         e = '0;
         if (rst) begin
            hist_q = '{8'h00, 8'h00};
            win_q.delete();
            for (int i = 0; i < D; i++) win_q.push_back(8'h00);
            mdl_out = 8'h00;
         end else begin
            hist_q.push_back({~sens_raw, mot_raw});
            win_q.push_back(hist_q.pop_front());
            void'(win_q.pop_front());
            nxt = mdl_out;
            for (int c = 0; c < 8; c++) begin
               flip = 1'b1;
               foreach (win_q[i]) if (win_q[i][c] == mdl_out[c]) flip = 1'b0;
               if (flip) nxt[c] = ~mdl_out[c];
            end
            e.evt   = |(nxt & ~mdl_out);
            e.any   = |nxt;
            mdl_out = nxt;
         end
         e.mot  = mdl_out[4:0];
         e.sens = ~mdl_out[7:5];
         exp_q.push_back(e);
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (fault_evt) evt_count++;
         if (exp_q.size() == 0) begin
            check_output("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            check_output("mot_err", 32'(mot_err), 32'(e.mot));
            check_output("fail_sensn", 32'(fail_sensn), 32'(e.sens));
            check_output("fault_evt", 32'(fault_evt), 32'(e.evt));
            check_output("fault_any", 32'(fault_any), 32'(e.any));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;

      // Reset, then idle.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check_output("idle_mot", 32'(mot_err), 32'h00);
      check_output("idle_sens", 32'(fail_sensn), 32'h7);

      // Qualified fault: rise and fall each take six edges, pulse only on the rise.
      apply_stimulus(5'b00001, 3'b111);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_output("rise_early", 32'(mot_err[0]), 32'd0);
      end
      @(posedge clk); #1;
      check_output("rise_edge", 32'(mot_err[0]), 32'd1);
      check_output("rise_evt", 32'(fault_evt), 32'd1);
      check_output("rise_any", 32'(fault_any), 32'd1);
      repeat (4) @(negedge clk);
      apply_stimulus(5'b00000, 3'b111);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_output("fall_early", 32'(mot_err[0]), 32'd1);
      end
      @(posedge clk); #1;
      check_output("fall_edge", 32'(mot_err[0]), 32'd0);
      check_output("fall_any", 32'(fault_any), 32'd0);
      check_output("fall_evt", 32'(fault_evt), 32'd0);

      // Glitch rejection: three cycles of sensor fault.
      base = evt_count;
      apply_stimulus(5'b00000, 3'b110);
      repeat (2) @(negedge clk);
      apply_stimulus(5'b00000, 3'b111);
      repeat (10) @(negedge clk);
      check_output("glitch_evt_count", 32'(evt_count - base), 32'd0);
      check_output("glitch_sens", 32'(fail_sensn), 32'h7);

      // Chatter on MOT_ERR_RAW[2] every two cycles, then hold.
      base = evt_count;
      for (int i = 0; i < 10; i++) begin
         apply_stimulus((i % 2 == 0) ? 5'b00100 : 5'b00000, 3'b111);
         @(negedge clk);
      end
      apply_stimulus(5'b00100, 3'b111);
      repeat (10) @(negedge clk);
      check_output("chatter_evt_count", 32'(evt_count - base), 32'd1);
      check_output("chatter_mot", 32'(mot_err), 32'h04);
      apply_stimulus(5'b00000, 3'b111);
      repeat (10) @(negedge clk);

      // Simultaneous faults produce one pulse.
      base = evt_count;
      apply_stimulus(5'b10000, 3'b110);
      repeat (5) @(posedge clk);
      @(posedge clk); #1;
      check_output("simul_mot", 32'(mot_err), 32'h10);
      check_output("simul_sens", 32'(fail_sensn), 32'h6);
      repeat (5) @(negedge clk);
      check_output("simul_evt_count", 32'(evt_count - base), 32'd1);

      // Reset mid-debounce with faults held; outputs clear at once.
      apply_stimulus(5'b10001, 3'b110);
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_output("rst_async_mot", 32'(mot_err), 32'h00);
      check_output("rst_async_sens", 32'(fail_sensn), 32'h7);
      check_output("rst_async_any", 32'(fault_any), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_output("rst_requal_early", 32'(mot_err), 32'h00);
      end
      @(posedge clk); #1;
      check_output("rst_requal_mot", 32'(mot_err), 32'h11);
      check_output("rst_requal_sens", 32'(fail_sensn), 32'h6);
      check_output("rst_requal_evt", 32'(fault_evt), 32'd1);

      // Randomised mix of short glitches and long holds on all channels.
      for (int i = 0; i < 300; i++) begin
         apply_stimulus(5'($urandom), 3'($urandom));
         repeat ($urandom_range(0, 7)) @(negedge clk);
      end

      apply_stimulus(5'b00000, 3'b111);
      repeat (20) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
